// File: rtl/nano_dsi_data_rx.sv
// nano_dsi_data_rx: LP start-of-transmission detection, HS sync search and byte deserializer for one data lane.
// Build option: define NANO_DSI_RX_SYNC_TOL_EN to accept a sync byte with at most one bit in error.
module nano_dsi_data_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lp_p,
  input  logic       lp_n,
  input  logic       hs_bit,
  input  logic [7:0] cfg_sync_to,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  output logic       rx_sot,
  output logic       rx_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_LP01    = 3'd1,
    ST_LP00    = 3'd2,
    ST_HS_SYNC = 3'd3,
    ST_HS_DATA = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

`ifdef NANO_DSI_RX_SYNC_TOL_EN
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction
`endif

  function automatic logic sync_match(input logic [7:0] w);
`ifdef NANO_DSI_RX_SYNC_TOL_EN
    return (popcount8(w ^ SYNC_BYTE) <= 4'd1);
`else
    return (w == SYNC_BYTE);
`endif
  endfunction

  logic       lp_p_meta_r, lp_n_meta_r;
  logic       lp_p_s, lp_n_s;
  logic [1:0] lp_s;

  state_t     state_r, next_state_s;
  logic [7:0] window_r, window_nx_s, shifted_s;
  logic [7:0] timer_r, timer_nx_s;
  logic [2:0] bit_cnt_r, bit_cnt_nx_s;
  logic [7:0] hold_data_r, hold_data_nx_s;
  logic       hold_full_r, hold_full_nx_s;
  logic       armed_r, armed_nx_s;
  logic       lp11_seen_r, lp11_seen_nx_s;
  logic       byte_done_s, eot_s;
  logic [7:0] data_nx_s;
  logic       valid_nx_s, last_nx_s, sot_nx_s, err_nx_s;

  // Two-flop synchronizers for the asynchronous LP receiver outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_p_meta_r <= 1'b1;
      lp_n_meta_r <= 1'b1;
      lp_p_s      <= 1'b1;
      lp_n_s      <= 1'b1;
    end else begin
      lp_p_meta_r <= lp_p;
      lp_n_meta_r <= lp_n;
      lp_p_s      <= lp_p_meta_r;
      lp_n_s      <= lp_n_meta_r;
    end
  end

  assign lp_s        = {lp_p_s, lp_n_s};
  assign shifted_s   = {hs_bit, window_r[7:1]};
  assign byte_done_s = (bit_cnt_r == 3'd7);
  assign eot_s       = (lp_s == 2'b11) && lp11_seen_r;

  // Next-state, datapath and output decode
  always_comb begin
    next_state_s   = state_r;
    window_nx_s    = window_r;
    timer_nx_s     = timer_r;
    bit_cnt_nx_s   = bit_cnt_r;
    hold_data_nx_s = hold_data_r;
    hold_full_nx_s = hold_full_r;
    armed_nx_s     = armed_r;
    lp11_seen_nx_s = 1'b0;
    data_nx_s      = 8'h00;
    valid_nx_s     = 1'b0;
    last_nx_s      = 1'b0;
    sot_nx_s       = 1'b0;
    err_nx_s       = 1'b0;
    case (state_r)
      ST_STOP: begin
        // A new request is accepted only after LP11 has been seen in stop
        if (lp_s == 2'b11) begin
          armed_nx_s = 1'b1;
        end else if (armed_r && (lp_s == 2'b01)) begin
          armed_nx_s   = 1'b0;
          next_state_s = ST_LP01;
        end else begin
          armed_nx_s = armed_r;
        end
      end
      ST_LP01: begin
        case (lp_s)
          2'b00:   next_state_s = ST_LP00;
          2'b11:   next_state_s = ST_STOP;
          2'b10: begin
            next_state_s = ST_STOP;
            err_nx_s     = 1'b1;
          end
          default: next_state_s = ST_LP01;
        endcase
      end
      ST_LP00: begin
        next_state_s   = ST_HS_SYNC;
        window_nx_s    = 8'h00;
        timer_nx_s     = cfg_sync_to;
        hold_full_nx_s = 1'b0;
      end
      ST_HS_SYNC: begin
        window_nx_s = shifted_s;
        if (lp_s == 2'b11) begin
          next_state_s = ST_STOP;
        end else if (sync_match(shifted_s)) begin
          next_state_s = ST_HS_DATA;
          bit_cnt_nx_s = 3'd0;
          sot_nx_s     = 1'b1;
        end else if (timer_r <= 8'd1) begin
          next_state_s = ST_STOP;
          err_nx_s     = 1'b1;
        end else begin
          timer_nx_s = timer_r - 8'd1;
        end
      end
      ST_HS_DATA: begin
        window_nx_s    = shifted_s;
        bit_cnt_nx_s   = bit_cnt_r + 3'd1;
        lp11_seen_nx_s = (lp_s == 2'b11);
        if (eot_s) begin
          next_state_s   = ST_STOP;
          hold_full_nx_s = 1'b0;
          // On a coincident completion the held byte was flushed one cycle earlier
          if (byte_done_s) begin
            data_nx_s  = shifted_s;
            valid_nx_s = 1'b1;
            last_nx_s  = 1'b1;
          end else if (hold_full_r) begin
            data_nx_s  = hold_data_r;
            valid_nx_s = 1'b1;
            last_nx_s  = 1'b1;
          end else begin
            valid_nx_s = 1'b0;
          end
        end else if (byte_done_s) begin
          hold_data_nx_s = shifted_s;
          hold_full_nx_s = 1'b1;
          if (hold_full_r) begin
            data_nx_s  = hold_data_r;
            valid_nx_s = 1'b1;
          end else begin
            valid_nx_s = 1'b0;
          end
        end else if ((lp_s == 2'b11) && (bit_cnt_r == 3'd6) && hold_full_r) begin
          // EoT may land on the next completion: release the held byte now
          data_nx_s      = hold_data_r;
          valid_nx_s     = 1'b1;
          hold_full_nx_s = 1'b0;
        end else begin
          valid_nx_s = 1'b0;
        end
      end
      default: begin
        next_state_s   = ST_STOP;
        hold_full_nx_s = 1'b0;
      end
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_STOP;
      window_r    <= 8'h00;
      timer_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      hold_data_r <= 8'h00;
      hold_full_r <= 1'b0;
      armed_r     <= 1'b0;
      lp11_seen_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      window_r    <= window_nx_s;
      timer_r     <= timer_nx_s;
      bit_cnt_r   <= bit_cnt_nx_s;
      hold_data_r <= hold_data_nx_s;
      hold_full_r <= hold_full_nx_s;
      armed_r     <= armed_nx_s;
      lp11_seen_r <= lp11_seen_nx_s;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
      rx_sot   <= 1'b0;
      rx_err   <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      rx_data  <= data_nx_s;
      rx_valid <= valid_nx_s;
      rx_last  <= last_nx_s;
      rx_sot   <= sot_nx_s;
      rx_err   <= err_nx_s;
      rx_busy  <= (next_state_s != ST_STOP);
    end
  end

endmodule

// File: doc/nano_dsi_data_rx.md
NANO_DSI_DATA_RX -- requirements
Module: nano_dsi_data_rx

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: single clock domain; all logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- lp_p / lp_n, in, 1 each: raw LP receiver outputs; asynchronous to clk.
- hs_bit, in, 1: HS comparator sample; synchronous to clk; one bit per cycle.
- cfg_sync_to, in, 8: sync-search timeout, in cycles.
- rx_data, out, 8: received byte, LSB-first on the wire.
- rx_valid, out, 1: rx_data is valid this cycle; single-cycle pulse.
- rx_last, out, 1: qualifies rx_valid; marks the final byte of a burst.
- rx_sot, out, 1: one-cycle pulse when the sync byte is found.
- rx_err, out, 1: one-cycle pulse on sync timeout or malformed LP sequence.
- rx_busy, out, 1: high in any state other than ST_STOP.

Function
REQ-002 lp_p and lp_n SHALL each pass through a 2-flop synchronizer before any use; lp_p_s and lp_n_s denote the synchronized values.
REQ-003 The FSM SHALL have these states: ST_STOP, ST_LP01, ST_LP00, ST_HS_SYNC, ST_HS_DATA.
REQ-004 ST_STOP -> ST_LP01 when {lp_p_s,lp_n_s}==01.
REQ-005 ST_LP01 -> ST_LP00 on 00; -> ST_STOP on 11; -> ST_STOP with an rx_err pulse on 10.
REQ-006 ST_LP00 -> ST_HS_SYNC on the first cycle in ST_LP00, and SHALL clear the sync window to 8'h00 on that transition.
REQ-007 In ST_HS_SYNC and ST_HS_DATA, the 8-bit window SHALL shift right every cycle, with hs_bit entering at bit 7.
REQ-008 ST_HS_SYNC -> ST_HS_DATA in the cycle the updated window equals 8'hB8; rx_sot SHALL pulse one cycle later, and the bit counter SHALL reset to 0.
REQ-009 The sync-search timer SHALL load cfg_sync_to on entry to ST_HS_SYNC and decrement each cycle.
REQ-010 When the timer reaches 0 without a match, the FSM SHALL pulse rx_err and return to ST_STOP, which then waits for LP11 before accepting a new request.
REQ-011 In ST_HS_DATA, every 8 bits SHALL complete one byte (the window contents) into a one-byte hold register.
REQ-012 If the hold register is already full when a byte completes, the held byte SHALL be emitted (rx_valid=1, rx_last=0) in the same cycle the new byte is loaded.
REQ-013 EoT SHALL be detected as {lp_p_s,lp_n_s}==11 for 2 consecutive cycles in ST_HS_DATA.
REQ-014 On EoT, the held byte (if any) SHALL be emitted with rx_last=1, partial bits SHALL be discarded, and the FSM SHALL go to ST_STOP.
REQ-015 If the hold register is empty at EoT, no byte SHALL be emitted.
REQ-016 EoT SHALL be detected only in ST_HS_DATA; LP11 during ST_HS_SYNC SHALL cause a return to ST_STOP without rx_err.
REQ-017 If EoT and byte completion fall on the same cycle, the completing byte SHALL be emitted as last and the previously held byte one cycle earlier; rx_valid SHALL never carry two bytes in one cycle.
REQ-018 All outputs SHALL be registered.
REQ-019 rx_valid SHALL never be asserted outside ST_HS_DATA and its EoT-exit cycle.
REQ-020 Trail bits are not stripped; the consumer uses the packet length.

Reset
REQ-021 Asserting rst_n low SHALL asynchronously force the FSM to ST_STOP.
REQ-022 The synchronizers SHALL reset to 11 and the hold register to empty.
REQ-023 During reset, rx_data=0, rx_valid=0, rx_last=0, rx_sot=0, rx_err=0, and rx_busy=0.
REQ-024 A reset during a burst SHALL drop the held byte with no output pulse.
REQ-025 Reset deassertion SHALL be synchronized externally.

Configuration
REQ-026 With NANO_DSI_RX_SYNC_TOL_EN defined, sync SHALL match when the window differs from 8'hB8 in at most 1 bit.
REQ-027 Without NANO_DSI_RX_SYNC_TOL_EN, sync SHALL require an exact match.
REQ-028 Only the sync comparator SHALL differ between the two builds.

Verification
REQ-029 Bench scenario: LP11 -> LP01 (4 cycles) -> LP00, 10 HS zeros, B8, bytes 0x12 0x34 0xA5, trail, LP11 -> rx_sot once, then rx_valid 3x with data 12,34,A5, rx_last only on A5, rx_err never.
REQ-030 Bench scenario: cfg_sync_to=20, HS zeros only -> rx_err pulses once at about 20 cycles, FSM in ST_STOP, rx_valid never.
REQ-031 Bench scenario: LP01 followed by LP10 -> rx_err pulse, no rx_sot.
REQ-032 Bench scenario: sync pattern 8'hB9 (1-bit error) followed by byte 0x55 -> with NANO_DSI_RX_SYNC_TOL_EN, 0x55 is received as last; without it, there is no rx_sot and rx_err fires at timeout.
REQ-033 Bench scenario: rst_n low after byte 0x12 is held, mid-burst -> outputs 0 at once, no rx_valid, next burst received correctly.
REQ-034 Bench scenario: EoT coincident with completion of the second byte 0x77 (first 0x66) -> rx_valid for 0x66 (last=0), then the next cycle 0x77 (last=1).
